// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith ops, plus shift-add multiply and
// restoring divide (one bit per clock), with HI/LO registers for mfhi/mflo.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ulaOP,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    output logic [WIDTH-1:0] saidaULA,
    output logic [WIDTH-1:0] saidaHI,
    output logic [WIDTH-1:0] saidaLO,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             div_zero
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = (SW < 1) ? 1 : SW;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_REM  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_XOR  = 5'b01000;
    localparam logic [4:0] OP_NOR  = 5'b01001;
    localparam logic [4:0] OP_NAND = 5'b01010;
    localparam logic [4:0] OP_XNOR = 5'b01011;
    localparam logic [4:0] OP_SLL  = 5'b01100;
    localparam logic [4:0] OP_SRL  = 5'b01101;
    localparam logic [4:0] OP_GT   = 5'b01110;
    localparam logic [4:0] OP_MFHI = 5'b01111;
    localparam logic [4:0] OP_MFLO = 5'b10000;
    localparam logic [4:0] OP_PASS = 5'b11111;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               dz_q, dz_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   dz_res;
    logic [WIDTH-1:0]   fin_res;
    logic               is_mul, is_divrem, long_op;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: acc = {partial remainder, dividend bits turning into quotient bits}.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        alu_res = '0;
        unique case (ulaOP)
            OP_ADD:  alu_res = RS + RT;
            OP_SUB:  alu_res = RS - RT;
            OP_OR:   alu_res = RS | RT;
            OP_AND:  alu_res = RS & RT;
            OP_NOT:  alu_res = ~RS;
            OP_XOR:  alu_res = RS ^ RT;
            OP_NOR:  alu_res = ~(RS | RT);
            OP_NAND: alu_res = ~(RS & RT);
            OP_XNOR: alu_res = ~(RS ^ RT);
            OP_SLL:  alu_res = RS << RT[CW-1:0];
            OP_SRL:  alu_res = RS >> RT[CW-1:0];
            OP_GT:   alu_res = (RS > RT) ? WIDTH'(1) : '0;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_PASS: alu_res = RT;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        is_mul    = (ulaOP == OP_MUL);
        is_divrem = (ulaOP == OP_DIV) || (ulaOP == OP_REM);
        long_op   = is_mul || (is_divrem && (RT != '0));
        dz_res    = (ulaOP == OP_DIV) ? '1 : RS;
        step      = (kind_q == K_MUL) ? mul_next : div_next;
        fin_res   = (kind_q == K_REM) ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (long_op) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        opb_d   = RT;
                        acc_d   = {{WIDTH{1'b0}}, RS};
                        kind_d  = is_mul ? K_MUL : ((ulaOP == OP_DIV) ? K_DIV : K_REM);
                    end else if (is_divrem) begin
                        // Divide by zero finishes at once with a defined result.
                        lo_d   = '1;
                        hi_d   = RS;
                        res_d  = dz_res;
                        zero_d = (dz_res == '0);
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        res_d  = alu_res;
                        zero_d = (alu_res == '0);
                        dz_d   = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // HI/LO are the upper/lower halves of acc for both mul and div.
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = step[2*WIDTH-1:WIDTH];
                    lo_d    = step[WIDTH-1:0];
                    res_d   = fin_res;
                    zero_d  = (fin_res == '0);
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= K_MUL;
            cnt_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
        end
    end

    assign saidaULA = res_q;
    assign saidaHI  = hi_q;
    assign saidaLO  = lo_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign zero     = zero_q;
    assign div_zero = dz_q;

endmodule
